snn_cls_sched: RTL and testbench
================================

# snn_cls_sched

Sequencer for the classification-layer output neurons. Runs one inference window: clears the neuron spike counters, holds their enable for a fixed number of timesteps, waits for their two-stage edge-detect pipeline to drain, then scans the potentials one per cycle and reports the winning class. Sits between the top-level inference controller (start/done) and the array of output-neuron counters (enable/clear/potential readback).

## Interface
- N_CLASS, 2, number of output neurons/classes (≥2)
- CNT_W, 3, width of each neuron potential
- T_STEPS, 8, timesteps per inference window (≥1)
- STEP_CYC, 4, clock cycles per timestep (≥1)
- CID_W, max(1, clog2(N_CLASS)), class index width (derived)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request one inference window; sampled only in IDLE
- abort  in  1  synchronous abort of the current window
- pot_in  in  N_CLASS*CNT_W  neuron potentials; class i at bits [i*CNT_W +: CNT_W]
- en_u  out  1  neuron count enable
- clr_u  out  1  neuron counter clear, one-cycle pulse
- step_tick  out  1  pulse on the last cycle of each timestep
- step_idx  out  clog2(T_STEPS+1)  current timestep index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result strobe
- class_id  out  CID_W  winning class index
- tie  out  1  another class equalled the winning potential
- no_spike  out  1  winning potential is zero

## Operation
- States: IDLE → CLEAR → RUN → DRAIN → SCAN → DONE → IDLE.
- IDLE: all strobes low. start=1 and abort=0 → CLEAR.
- CLEAR: one cycle, clr_u=1. Best register ← 0, scan index ← 0, tie_r ← 0.
- RUN: T_STEPS*STEP_CYC cycles with en_u=1.
  - Cycle counter cyc counts 0..STEP_CYC-1. step_tick=1 when cyc=STEP_CYC-1.
  - step_idx increments after each tick.
  - Leave RUN after the final tick.
- DRAIN: exactly 2 cycles, en_u=0. Covers the neurons' 2-register edge pipeline.
- SCAN: N_CLASS cycles. Cycle i compares p=pot_in[i] against the best value.
  - i=0 or p>best: best←p, idx←i, tie_r←0.
  - p==best and i>0: tie_r←1, idx unchanged. Ties resolve to the lowest index.
  - Potentials are unsigned CNT_W. No saturation logic here.
- DONE: one cycle, done=1. class_id←idx, tie←tie_r, no_spike←(best==0). All three are registered on DONE entry so they are valid while done=1, and hold until the next DONE.
- abort=1 in any non-IDLE state → IDLE next cycle. No done strobe; en_u drops next cycle; class_id, tie and no_spike are unchanged.
- start while busy is ignored, not queued. start and abort together in IDLE: abort wins, stay IDLE.
- Reset, including mid-window: state IDLE. en_u, clr_u, step_tick, busy, done, tie and no_spike all 0; class_id=0; step_idx=0; all internal counters 0.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from start/abort/pot_in to any output.
- Let start be sampled high at edge of cycle 0.
  - clr_u: cycle 1.
  - en_u: cycles 2 .. T_STEPS*STEP_CYC+1.
  - DRAIN: the next 2 cycles.
  - SCAN: N_CLASS cycles.
  - done: cycle T_STEPS*STEP_CYC+N_CLASS+4. Defaults: cycle 38.
- busy rises in cycle 1 and falls in the cycle after done. The earliest next start is sampled in the cycle after done.
- pot_in must be stable throughout SCAN. The controller guarantees this because en_u=0 from DRAIN onward.
- step_idx equals T_STEPS from the final tick until the next CLEAR. It clears to 0 in CLEAR.

## Test plan
- Defaults; start pulse; pot_in={cls1=5, cls0=3} → clr_u in cycle 1, en_u high for 32 cycles, 8 step_tick pulses, done in cycle 38, class_id=1, tie=0, no_spike=0.
- pot_in={4,4} → class_id=0, tie=1. pot_in={0,0} → class_id=0, tie=1, no_spike=1.
- N_CLASS=4, pot_in={2,7,7,1} (cls3..cls0) → class_id=1, tie=1, done in cycle 32+4+4=40.
- abort in RUN step 3 → en_u low next cycle, busy low, no done, class_id keeps its previous value. A new start then gives a full normal window.
- start pulses while busy and start+abort together in IDLE → no effect. Exactly one done per accepted start.
- rst_n asserted in SCAN → all outputs 0 immediately (async). After release, a start gives correct timing from cycle 0.

Source files
------------

// File: rtl/snn_cls_sched.sv
// Inference-window sequencer for the classification-layer output neurons.
// Clears the counters, enables them for T_STEPS timesteps, drains the edge pipeline, then scans the potentials for the winning class.
module snn_cls_sched #(
  parameter int unsigned N_CLASS  = 2,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned T_STEPS  = 8,
  parameter int unsigned STEP_CYC = 4,
  localparam int unsigned CID_W   = (N_CLASS > 2) ? $clog2(N_CLASS) : 1,
  localparam int unsigned SW      = $clog2(T_STEPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_CLASS*CNT_W-1:0] pot_in,
  output logic                     en_u,
  output logic                     clr_u,
  output logic                     step_tick,
  output logic [SW-1:0]            step_idx,
  output logic                     busy,
  output logic                     done,
  output logic [CID_W-1:0]         class_id,
  output logic                     tie,
  output logic                     no_spike
);

  localparam int unsigned CYC_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(STEP_CYC - 1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(T_STEPS - 1);
  localparam logic [CID_W-1:0] IDX_LAST  = CID_W'(N_CLASS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_SCAN, S_DONE
  } state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [CYC_W-1:0]  cyc_nx;
  logic              drain_cnt;
  logic [CID_W-1:0]  sidx;
  logic [CID_W-1:0]  best_idx;
  logic [CID_W-1:0]  idx_nx;
  logic [CNT_W-1:0]  best;
  logic [CNT_W-1:0]  best_nx;
  logic [CNT_W-1:0]  pot_cur;
  logic              tie_r;
  logic              tie_nx;

  // Select the potential of the class currently being scanned
  always_comb begin
    pot_cur = '0;
    for (int i = 0; i < int'(N_CLASS); i++) begin
      if (sidx == CID_W'(i)) pot_cur = pot_in[i*CNT_W +: CNT_W];
    end
  end

  // One scan step: strictly greater takes over, equal keeps the lower index and flags a tie
  always_comb begin
    best_nx = best;
    idx_nx  = best_idx;
    tie_nx  = tie_r;
    if (sidx == '0 || pot_cur > best) begin
      best_nx = pot_cur;
      idx_nx  = sidx;
      tie_nx  = 1'b0;
    end else if (pot_cur == best) begin
      tie_nx  = 1'b1;
    end
  end

  assign cyc_nx = (cyc == CYC_LAST) ? '0 : cyc + CYC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cyc       <= '0;
      drain_cnt <= 1'b0;
      sidx      <= '0;
      best_idx  <= '0;
      best      <= '0;
      tie_r     <= 1'b0;
      en_u      <= 1'b0;
      clr_u     <= 1'b0;
      step_tick <= 1'b0;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_id  <= '0;
      tie       <= 1'b0;
      no_spike  <= 1'b0;
    end else if (state != S_IDLE && abort) begin
      state     <= S_IDLE;
      en_u      <= 1'b0;
      clr_u     <= 1'b0;
      step_tick <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state    <= S_CLEAR;
            clr_u    <= 1'b1;
            busy     <= 1'b1;
            step_idx <= '0;
            cyc      <= '0;
          end
        end
        S_CLEAR: begin
          state     <= S_RUN;
          clr_u     <= 1'b0;
          en_u      <= 1'b1;
          cyc       <= '0;
          step_tick <= (CYC_LAST == '0);
          best      <= '0;
          best_idx  <= '0;
          sidx      <= '0;
          tie_r     <= 1'b0;
        end
        S_RUN: begin
          cyc <= cyc_nx;
          // step_tick is registered one cycle ahead so it lines up with cyc == CYC_LAST
          if (cyc == CYC_LAST) begin
            step_idx <= step_idx + SW'(1);
            if (step_idx == STEP_LAST) begin
              state     <= S_DRAIN;
              en_u      <= 1'b0;
              step_tick <= 1'b0;
              drain_cnt <= 1'b0;
            end else begin
              step_tick <= (CYC_LAST == '0);
            end
          end else begin
            step_tick <= (cyc_nx == CYC_LAST);
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_SCAN;
            sidx  <= '0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_SCAN: begin
          best     <= best_nx;
          best_idx <= idx_nx;
          tie_r    <= tie_nx;
          if (sidx == IDX_LAST) begin
            state    <= S_DONE;
            done     <= 1'b1;
            class_id <= idx_nx;
            tie      <= tie_nx;
            no_spike <= (best_nx == '0);
          end else begin
            sidx <= sidx + CID_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_cls_sched.sv
// Randomized self-checking bench for snn_cls_sched: a 2-class and a 4-class instance run side by side
// against a per-cycle window-timing model and an argmax reference for the classification result.
module tb_snn_cls_sched;

  localparam int STEP = 4;
  localparam int TS   = 8;
  localparam int CNT  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [5:0]  pot2;
  logic [11:0] pot4;

  logic       en2, clr2, tick2, busy2, done2, tie2, ns2;
  logic [3:0] sidx2;
  logic [0:0] cid2;
  logic       en4, clr4, tick4, busy4, done4, tie4, ns4;
  logic [3:0] sidx4;
  logic [1:0] cid4;

  int n_chk  = 0;
  int n_fail = 0;

  int m_cls  [2];
  int m_tie  [2];
  int m_ns   [2];
  int m_step [2];

  snn_cls_sched #(.N_CLASS(2), .CNT_W(3), .T_STEPS(8), .STEP_CYC(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pot_in(pot2),
    .en_u(en2), .clr_u(clr2), .step_tick(tick2), .step_idx(sidx2), .busy(busy2),
    .done(done2), .class_id(cid2), .tie(tie2), .no_spike(ns2)
  );

  snn_cls_sched #(.N_CLASS(4), .CNT_W(3), .T_STEPS(8), .STEP_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pot_in(pot4),
    .en_u(en4), .clr_u(clr4), .step_tick(tick4), .step_idx(sidx4), .busy(busy4),
    .done(done4), .class_id(cid4), .tie(tie4), .no_spike(ns4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference winner: highest potential, lowest index among equals
  task automatic ref_result(input int n, input logic [11:0] pv, output int cls, output int t, output int ns);
    int best;
    int cnt;
    best = 0;
    for (int i = 0; i < n; i++) if (int'(pv[i*CNT +: CNT]) > best) best = int'(pv[i*CNT +: CNT]);
    cls = -1;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(pv[i*CNT +: CNT]) == best) begin
        cnt++;
        if (cls < 0) cls = i;
      end
    end
    t  = (cnt > 1) ? 1 : 0;
    ns = (best == 0) ? 1 : 0;
  endtask

  // Compare one DUT in cycle k of a window (k=1 is the cycle after start was sampled)
  task automatic check_dut(input int d, input int n, input int k, input int ak,
                           input logic en, input logic clr, input logic tick, input int sidx,
                           input logic bsy, input logic dn, input int cid, input logic tq,
                           input logic ns, input logic [11:0] pv);
    int dc;
    bit win;
    string s;
    dc  = TS*STEP + n + 4;
    win = (k >= 1) && (k <= dc) && (ak == 0 || k <= ak);
    if (win && k == dc) ref_result(n, pv, m_cls[d], m_tie[d], m_ns[d]);
    if (win) m_step[d] = (k == 1) ? 0 : (k <= TS*STEP + 1) ? (k - 2) / STEP : TS;
    s = $sformatf("n%0d k%0d", n, k);
    check({"busy ", s}, int'(bsy), int'(win));
    check({"clr_u ", s}, int'(clr), int'(win && k == 1));
    check({"en_u ", s}, int'(en), int'(win && k >= 2 && k <= TS*STEP + 1));
    check({"step_tick ", s}, int'(tick), int'(win && k >= 2 && k <= TS*STEP + 1 && (k - 2) % STEP == STEP - 1));
    check({"done ", s}, int'(dn), int'(win && k == dc));
    check({"step_idx ", s}, sidx, m_step[d]);
    check({"class_id ", s}, cid, m_cls[d]);
    check({"tie ", s}, int'(tq), m_tie[d]);
    check({"no_spike ", s}, int'(ns), m_ns[d]);
  endtask

  task automatic check_both(input int k, input int ak);
    check_dut(0, 2, k, ak, en2, clr2, tick2, int'(sidx2), busy2, done2, int'(cid2), tie2, ns2, {6'd0, pot2});
    check_dut(1, 4, k, ak, en4, clr4, tick4, int'(sidx4), busy4, done4, int'(cid4), tie4, ns4, pot4);
  endtask

  // One window; ak>0 raises abort during cycle ak; noisy adds stray start pulses while busy
  task automatic run_window(input logic [5:0] p2, input logic [11:0] p4, input int ak, input bit noisy);
    pot2  = p2;
    pot4  = p4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      check_both(k, ak);
      abort = (k == ak);
      start = noisy && (k <= 37) && (ak == 0 || k <= ak) && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic reset_models();
    for (int d = 0; d < 2; d++) begin
      m_cls[d] = 0; m_tie[d] = 0; m_ns[d] = 0; m_step[d] = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ak;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pot2  = '0;
    pot4  = '0;
    reset_models();
    repeat (3) @(posedge clk);
    #1;
    check_both(0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed classification windows
    run_window({3'd5, 3'd3}, {3'd2, 3'd7, 3'd7, 3'd1}, 0, 1'b0);
    run_window({3'd4, 3'd4}, 12'($urandom), 0, 1'b1);
    run_window({3'd0, 3'd0}, 12'd0, 0, 1'b0);

    // Abort in RUN step 3, then a full window
    run_window(6'($urandom), 12'($urandom), 15, 1'b1);
    run_window(6'($urandom), 12'($urandom), 0, 1'b0);

    // start together with abort in IDLE does nothing
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_both(100, 0);
      @(posedge clk); #1;
    end

    // Asynchronous reset in SCAN, then a clean window
    pot2  = 6'($urandom);
    pot4  = 12'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 2; k <= 37; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    reset_models();
    check_both(0, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_window(6'($urandom), 12'($urandom), 0, 1'b1);

    // Random windows, some aborted part-way
    for (int w = 0; w < 8; w++) begin
      ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 37)) : 0;
      run_window(6'($urandom), 12'($urandom), ak, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
